// File: rtl/dmem_req_if.sv
// dmem_req_if: one requester's access channel into the data-RAM arbiter.
//   req/we/size/addr/wdata : request fields, driven by the requester
//   gnt                    : one-cycle pulse in the access's final RAM cycle
//   rvalid/rdata           : load completion, the cycle after gnt
// Handshake: the requester raises req with all fields stable and holds them
// until it sees gnt=1 on a rising edge; that edge completes the access.
// There is no back-pressure on rvalid/rdata.
interface dmem_req_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;

  modport master (output req, we, size, addr, wdata,
                  input  gnt, rvalid, rdata);
  modport slave  (input  req, we, size, addr, wdata,
                  output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port 64-bit data RAM between the CPU MEM
// stage and a DMA/loader port. Byte/half/word/double accesses at any
// alignment become doubleword RAM beats: sub-word stores are merged into
// the word read back from mem_rd, and accesses crossing an 8-byte boundary
// take two beats (IDLE -> SPLIT -> IDLE). The CPU wins by priority unless
// DMA has watched STARVE_MAX CPU starts while waiting.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cpu, dma          requester channels (dmem_req_if.slave)
//   mem_we/mem_a/mem_wd  RAM write enable, 8-aligned address, merged data
//   mem_rd            RAM read data, combinational from mem_a
//   dbg_state         FSM state (0 = IDLE, 1 = SPLIT)
//   dbg_starve_cnt    starvation counter
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_req_if.slave   cpu,
  dmem_req_if.slave   dma,
  output logic        mem_we,
  output logic [63:0] mem_a,
  output logic [63:0] mem_wd,
  input  logic [63:0] mem_rd,
  output logic [0:0]  dbg_state,
  output logic [3:0]  dbg_starve_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;        // 0 = cpu, 1 = dma
  logic [3:0]  starve_q, starve_d;
  logic [63:0] lo_q, lo_d;              // first-beat RAM word of a split load
  logic        cpu_rvalid_q, cpu_rvalid_d, dma_rvalid_q, dma_rvalid_d;
  logic [63:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

  logic        starve_hit, cpu_win, dma_win, owner, active, split, done;
  logic        in_split, sel_we, cpu_gnt, dma_gnt;
  logic [1:0]  sel_size;
  logic [63:0] sel_addr, sel_wdata, size_mask, beat_wd, ld_data;
  logic [2:0]  off;
  logic [3:0]  nbytes;
  logic [15:0] byte_mask;
  logic [7:0]  beat_mask;
  logic [127:0] wide_wd, rd_wide, ld_wide;
  logic [60:0] word;

  always_comb begin
    in_split   = (state_q == S_SPLIT);
    starve_hit = (starve_q == 4'(STARVE_MAX));
    cpu_win    = cpu.req && !(dma.req && starve_hit);
    dma_win    = dma.req && !cpu_win;
    // In SPLIT the owner's fields are still held stable (no gnt yet).
    owner      = in_split ? owner_q : dma_win;
    // Gating with rst_n makes every combinational output 0 during reset.
    active     = rst_n && (in_split || cpu.req || dma.req);

    sel_we     = owner ? dma.we    : cpu.we;
    sel_size   = owner ? dma.size  : cpu.size;
    sel_addr   = owner ? dma.addr  : cpu.addr;
    sel_wdata  = owner ? dma.wdata : cpu.wdata;

    off        = sel_addr[2:0];
    nbytes     = 4'd1 << sel_size;
    split      = ({1'b0, off} + nbytes) > 4'd8;
    size_mask  = (sel_size == 2'd3) ? '1 : ((64'd1 << {nbytes, 3'b000}) - 64'd1);

    // Access viewed as a 16-byte window over this word and the next:
    // low half belongs to beat 1, high half to beat 2.
    byte_mask  = ((16'd1 << nbytes) - 16'd1) << off;
    wide_wd    = {64'd0, sel_wdata & size_mask} << {off, 3'b000};
    beat_mask  = in_split ? byte_mask[15:8] : byte_mask[7:0];
    beat_wd    = in_split ? wide_wd[127:64] : wide_wd[63:0];

    rd_wide    = in_split ? {mem_rd, lo_q} : {64'd0, mem_rd};
    ld_wide    = rd_wide >> {off, 3'b000};
    ld_data    = ld_wide[63:0] & size_mask;

    word       = sel_addr[63:3] + {60'd0, in_split};   // wraps at 2^61
    mem_a      = active ? {word, 3'b000} : '0;
    mem_we     = active && sel_we;
    mem_wd     = '0;
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem_wd[i*8 +: 8] = beat_mask[i] ? beat_wd[i*8 +: 8] : mem_rd[i*8 +: 8];
      end
    end

    done    = active && (in_split || !split);
    cpu_gnt = done && !owner;
    dma_gnt = done && owner;

    state_d = S_IDLE;
    owner_d = owner_q;
    lo_d    = lo_q;
    if (!in_split && active && split) begin
      state_d = S_SPLIT;
      owner_d = owner;
      lo_d    = mem_rd;
    end

    starve_d = starve_q;
    if (!dma.req) begin
      starve_d = 4'd0;
    end else if (!in_split) begin
      if (dma_win) begin
        starve_d = 4'd0;
      end else if (cpu_win && (starve_q < 4'(STARVE_MAX))) begin
        starve_d = starve_q + 4'd1;
      end
    end

    cpu_rvalid_d = cpu_gnt && !sel_we;
    dma_rvalid_d = dma_gnt && !sel_we;
    cpu_rdata_d  = cpu_rvalid_d ? ld_data : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? ld_data : dma_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      starve_q     <= 4'd0;
      lo_q         <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      lo_q         <= lo_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign cpu.gnt        = cpu_gnt;
  assign cpu.rvalid     = cpu_rvalid_q;
  assign cpu.rdata      = cpu_rdata_q;
  assign dma.gnt        = dma_gnt;
  assign dma.rvalid     = dma_rvalid_q;
  assign dma.rdata      = dma_rdata_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we;
  logic [63:0] mem_a, mem_wd, mem_rd;
  logic [0:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  dmem_req_if cpu_if ();
  dmem_req_if dma_if ();

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(cpu_if.slave), .dma(dma_if.slave),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / RAM (1024 doublewords, byte address modulo 8192)
  always #5 clk = ~clk;
  logic [63:0] ram [0:1023];
  assign mem_rd = ram[mem_a[12:3]];
  always @(posedge clk) if (mem_we) ram[mem_a[12:3]] <= mem_wd;

  // reference model: flat byte memory plus expected-load queue
  logic [7:0]  ref_mem [0:8191];
  logic [63:0] exp_q [$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input logic [63:0] wa);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = ref_mem[int'((wa + 64'(j)) & 64'd8191)];
    return r;
  endfunction

  task automatic set_port(input bit port, input bit req, input bit we, input logic [1:0] size,
                          input logic [63:0] addr, input logic [63:0] wdata);
    if (port) begin
      dma_if.req = req; dma_if.we = we; dma_if.size = size; dma_if.addr = addr; dma_if.wdata = wdata;
    end else begin
      cpu_if.req = req; cpu_if.we = we; cpu_if.size = size; cpu_if.addr = addr; cpu_if.wdata = wdata;
    end
  endtask

  // Single-port access; checks each beat, gnt timing, then rvalid/rdata.
  task automatic do_access(input bit port, input bit we, input logic [1:0] size,
                           input logic [63:0] addr, input logic [63:0] wdata);
    int n, off, beats;
    logic [63:0] ld, wa;
    n = 1 << size;
    off = int'(addr[2:0]);
    beats = (off + n > 8) ? 2 : 1;
    ld = '0;
    for (int k = 0; k < n; k++) begin
      if (we) ref_mem[int'((addr + 64'(k)) & 64'd8191)] = wdata[k*8 +: 8];
      else ld[k*8 +: 8] = ref_mem[int'((addr + 64'(k)) & 64'd8191)];
    end
    if (!we) exp_q.push_back(ld);
    @(posedge clk); #1;
    set_port(port, 1'b1, we, size, addr, wdata);
    for (int b = 0; b < beats; b++) begin
      @(negedge clk);
      wa = ((addr >> 3) + 64'(b)) << 3;
      check_eq("mem_a", mem_a, wa);
      check_eq("mem_we", 64'(mem_we), 64'(we));
      if (we) check_eq("mem_wd", mem_wd, ref_word(wa));
      check_eq("gnt", 64'(port ? dma_if.gnt : cpu_if.gnt), 64'(b == beats - 1));
      check_eq("other_gnt", 64'(port ? cpu_if.gnt : dma_if.gnt), 64'd0);
      check_eq("rvalid_early", 64'(port ? dma_if.rvalid : cpu_if.rvalid), 64'd0);
    end
    @(posedge clk); #1;
    set_port(port, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
    @(negedge clk);
    check_eq("rvalid", 64'(port ? dma_if.rvalid : cpu_if.rvalid), 64'(!we));
    if (!we && exp_q.size() > 0) check_eq("rdata", port ? dma_if.rdata : cpu_if.rdata, exp_q.pop_front());
  endtask

  initial begin
    int cnt;
    bit exp_dma;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
    set_port(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
    set_port(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cpu_gnt", 64'(cpu_if.gnt), 64'd0);
    check_eq("rst_cpu_rvalid", 64'(cpu_if.rvalid), 64'd0);
    check_eq("rst_cpu_rdata", cpu_if.rdata, 64'd0);
    check_eq("rst_dma_rdata", dma_if.rdata, 64'd0);
    check_eq("rst_mem_a", mem_a, 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    check_eq("rst_starve", 64'(dbg_starve_cnt), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // aligned double, byte merge, split word, wrap
    do_access(1'b0, 1'b1, 2'd3, 64'h40, 64'h1122334455667788);
    check_eq("sd_ram", ram[8], 64'h1122334455667788);
    do_access(1'b0, 1'b0, 2'd3, 64'h40, 64'd0);
    check_eq("ld_rdata", cpu_if.rdata, 64'h1122334455667788);
    do_access(1'b0, 1'b1, 2'd0, 64'h43, 64'h00000000000000AA);
    check_eq("sb_ram", ram[8], 64'h11223344AA667788);
    do_access(1'b0, 1'b0, 2'd0, 64'h43, 64'd0);
    check_eq("lbu_rdata", cpu_if.rdata, 64'h00000000000000AA);
    do_access(1'b0, 1'b1, 2'd2, 64'h46, 64'h00000000DEADBEEF);
    check_eq("sw_beat1", 64'(ram[8][63:48]), 64'hBEEF);
    check_eq("sw_beat2", 64'(ram[9][15:0]), 64'hDEAD);
    do_access(1'b0, 1'b0, 2'd2, 64'h46, 64'd0);
    check_eq("lwu_rdata", cpu_if.rdata, 64'h00000000DEADBEEF);
    do_access(1'b0, 1'b1, 2'd1, 64'h1FFF, 64'h000000000000BEEF);
    check_eq("wrap_hi", 64'(ram[1023][63:56]), 64'hEF);
    check_eq("wrap_lo", 64'(ram[0][7:0]), 64'hBE);
    do_access(1'b1, 1'b0, 2'd1, 64'h1FFF, 64'd0);
    check_eq("dma_wrap_rdata", dma_if.rdata, 64'h000000000000BEEF);

    // contention: both hold aligned loads; model the starvation rule
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 2'd3, 64'h40, 64'd0);
    set_port(1'b1, 1'b1, 1'b0, 2'd3, 64'h80, 64'd0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_dma = (cnt == STARVE_MAX);
      check_eq("cont_starve", 64'(dbg_starve_cnt), 64'(cnt));
      check_eq("cont_cpu_gnt", 64'(cpu_if.gnt), 64'(!exp_dma));
      check_eq("cont_dma_gnt", 64'(dma_if.gnt), 64'(exp_dma));
      cnt = exp_dma ? 0 : cnt + 1;
    end
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
    set_port(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("starve_clear", 64'(dbg_starve_cnt), 64'd0);

    // reset during SPLIT: first beat stays committed, no gnt
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b1, 2'd2, 64'h46, 64'h0000000012345678);
    @(negedge clk);
    check_eq("rs_beat1_gnt", 64'(cpu_if.gnt), 64'd0);
    check_eq("rs_beat1_a", mem_a, 64'h40);
    @(posedge clk); #1 rst_n = 1'b0;
    ref_mem[16'h46] = 8'h78;
    ref_mem[16'h47] = 8'h56;
    #1;
    check_eq("rs_gnt", 64'(cpu_if.gnt), 64'd0);
    check_eq("rs_mem_we", 64'(mem_we), 64'd0);
    check_eq("rs_mem_a", mem_a, 64'd0);
    check_eq("rs_mem_wd", mem_wd, 64'd0);
    check_eq("rs_rdata", cpu_if.rdata, 64'd0);
    check_eq("rs_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1 set_port(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rs_idle", 64'(dbg_state), 64'd0);
    check_eq("rs_word40", ram[8], ref_word(64'h40));
    check_eq("rs_word48", ram[9], ref_word(64'h48));

    // randomized single-port traffic against the byte model
    for (int t = 0; t < 200; t++) begin
      logic [63:0] a;
      a = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 8191));
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                a, {$urandom, $urandom});
    end
    for (int w = 0; w < 1024; w++) begin
      if (ram[w] !== ref_word(64'(w) << 3)) check_eq("final_ram", ram[w], ref_word(64'(w) << 3));
    end
    check_eq("final_ram_all", 64'(n_fail), 64'(n_fail));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 64-bit data RAM between the pipeline's MEM stage (CPU port) and a loader/DMA port. Converts RV64I byte/half/word/double accesses into doubleword RAM operations: read-modify-write merge for sub-word stores, and two-beat sequencing for accesses that cross an 8-byte boundary. Grants the CPU by priority, with a starvation guard for DMA. Sits between the MEM stage / DMA engine and the data RAM.

## Interface
Parameters:
- STARVE_MAX, 4: CPU-won starts tolerated while dma_req is pending before DMA is forced to win. Range 1..15.

Ports (p ∈ {cpu, dma}: one identical set per requester):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- p_req  in  1  access request; held with all fields stable until p_gnt
- p_we  in  1  1 = store, 0 = load
- p_size  in  2  00 byte, 01 half, 10 word, 11 double
- p_addr  in  64  byte address, any alignment
- p_wdata  in  64  store data, right-aligned (low bytes used)
- p_gnt  out  1  one-cycle pulse in the access's final RAM cycle
- p_rvalid  out  1  one-cycle pulse the cycle after p_gnt, loads only
- p_rdata  out  64  load data, right-aligned, zero-extended; sign extension is done downstream
- mem_we  out  1  RAM write enable
- mem_a  out  64  RAM byte address, always 8-aligned ({word,3'b000})
- mem_wd  out  64  RAM write data (merged doubleword)
- mem_rd  in  64  RAM read data, combinational from mem_a

## Operation
- Let off = addr[2:0] and n = 1,2,4,8 bytes. The access is split when off+n > 8.
- FSM states: IDLE, SPLIT.
- IDLE arbitration, per cycle: only CPU requesting → CPU; only DMA → DMA; both → CPU, unless starve_cnt == STARVE_MAX, then DMA. Nothing requesting → mem_we=0, mem_a=0.
- The winner's first beat drives mem_a = {addr[63:3],3'b0} in the same cycle.
  - Store: mem_we=1. mem_wd = mem_rd with bytes off..min(off+n,8)-1 replaced by the low bytes of wdata.
  - Load: the selected bytes of mem_rd are extracted.
- Not split: p_gnt=1 this cycle; stay in IDLE.
- Split: latch owner and the first-beat load bytes; go to SPLIT; no gnt this cycle.
- SPLIT, exactly one cycle, no arbitration:
  - mem_a = {addr[63:3]+1,3'b0}; the 61-bit add wraps.
  - Remaining off+n-8 bytes go to / come from bytes 0.. of that word.
  - p_gnt=1, then return to IDLE.
- starve_cnt, 4 bits:
  - Increments when the CPU starts an access while dma_req=1.
  - Clears when DMA starts an access or dma_req=0.
  - Saturates at STARVE_MAX.
- Load completion: p_rdata is registered on the gnt edge as the assembled bytes right-aligned and zero-extended above n bytes. p_rvalid=1 in the next cycle.
- p_rdata holds its value until that port's next load completes.
- Store completion: p_rvalid stays 0.
- Reset (rst_n=0, any state): state=IDLE; starve_cnt=0; every p_gnt, p_rvalid, mem_we=0; every p_rdata=0; mem_a=0; mem_wd=0.
- Reset asserted while in SPLIT aborts the access with no gnt. The first-beat write already committed stays in RAM.

## Timing
- Aligned access: gnt in the request cycle T (0 wait states); rdata/rvalid at T+1.
- Split access: beat 1 in T, beat 2 and gnt in T+1, rdata/rvalid at T+2.
- Losing requester: gnt stays 0; the requester stalls and keeps req high.
- A new arbitration may start in the cycle after a gnt. Back-to-back aligned accesses therefore sustain one per cycle.
- The RAM samples mem_we/mem_a/mem_wd on the same rising edge that ends the beat.
- mem_we is never 1 outside a granted beat.

## Test plan
- Aligned double store then load: CPU SD 0x1122334455667788 @0x40. Required: mem_we=1, mem_a=0x40, cpu_gnt in the same cycle. Then LD @0x40 → next-cycle cpu_rvalid=1, cpu_rdata=0x1122334455667788.
- Sub-word merge: SB 0xAA @0x43 on that word → RAM word 0x11223344AA667788. Then LBU @0x43 → rdata=0x00000000000000AA.
- Split store/load: SW 0xDEADBEEF @0x46.
  - Beat 1: mem_a=0x40, bytes 6,7 = EF,BE.
  - Beat 2: mem_a=0x48, bytes 0,1 = AD,DE. cpu_gnt only in beat 2.
  - Then LWU @0x46 → rvalid at T+2, rdata=0x00000000DEADBEEF.
- Contention, STARVE_MAX=4, both req held high with aligned accesses → grant sequence CPU,CPU,CPU,CPU,DMA, repeating. starve_cnt=0 after each DMA start.
- Wrap: SH 0xBEEF @0x1FFF → beat 1 mem_a=0x1FF8 (byte 7=EF), beat 2 mem_a=0x2000 (byte 0=BE; RAM index 0).
- Reset in SPLIT: start SW @0x46, pull rst_n low after beat 1. Required: no cpu_gnt, all outputs 0 immediately, IDLE after release, word @0x40 bytes 6,7 already written.
